// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D round-robin sequencer.
package a2d_pkg;

  typedef enum logic [2:0] {IDLE, CMD1, WAIT1, GAP, CMD2, WAIT2, STORE} a2d_state_t;
  typedef enum logic [1:0] {R_LFT, R_RGHT, R_BATT} robin_t;

  function automatic logic [15:0] make_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  // The unused encoding 3 folds back to LFT so the pointer self-heals.
  function automatic robin_t robin_next(input robin_t r);
    case (r)
      R_LFT:   return R_RGHT;
      R_RGHT:  return R_BATT;
      default: return R_LFT;
    endcase
  endfunction

endpackage

// File: rtl/a2d_round_robin_ctrl.sv
// Round-robin A2D sequencer: each nxt runs a two-frame ADC128S conversion
// (address frame, then read frame) and latches the 12-bit result.
module a2d_round_robin_ctrl
  import a2d_pkg::*;
#(
  parameter logic [2:0] LFT_CH  = 3'd0,
  parameter logic [2:0] RGHT_CH = 3'd4,
  parameter logic [2:0] BATT_CH = 3'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        busy
);

  a2d_state_t  state_q, state_d;
  robin_t      ptr_q, ptr_d;
  logic [15:0] cmd_q, cmd_d;
  logic [11:0] lft_q, lft_d, rght_q, rght_d, batt_q, batt_d;
  logic        busy_q, busy_d;
  logic [2:0]  chan;
  logic        unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:12];

  always_comb begin
    case (ptr_q)
      R_RGHT:  chan = RGHT_CH;
      R_BATT:  chan = BATT_CH;
      default: chan = LFT_CH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= R_LFT;
      cmd_q   <= 16'h0000;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      batt_q  <= 12'h000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      batt_q  <= batt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cmd_d     = cmd_q;
    lft_d     = lft_q;
    rght_d    = rght_q;
    batt_d    = batt_q;
    busy_d    = busy_q;
    wrt       = 1'b0;
    cnv_cmplt = 1'b0;
    case (state_q)
      IDLE: begin
        // cmd is loaded here so its new value first appears in CMD1.
        if (nxt) begin
          cmd_d   = make_cmd(chan);
          busy_d  = 1'b1;
          state_d = CMD1;
        end
      end
      CMD1: begin
        wrt     = 1'b1;
        state_d = WAIT1;
      end
      WAIT1: if (done) state_d = GAP;
      GAP:   state_d = CMD2;
      CMD2: begin
        wrt     = 1'b1;
        state_d = WAIT2;
      end
      WAIT2: begin
        // ptr is still pointing at the channel addressed in CMD1.
        if (done) begin
          case (ptr_q)
            R_LFT:   lft_d  = rd_data[11:0];
            R_RGHT:  rght_d = rd_data[11:0];
            R_BATT:  batt_d = rd_data[11:0];
            default: ;
          endcase
          state_d = STORE;
        end
      end
      STORE: begin
        cnv_cmplt = 1'b1;
        busy_d    = 1'b0;
        ptr_d     = robin_next(ptr_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd     = cmd_q;
  assign lft_ld  = lft_q;
  assign rght_ld = rght_q;
  assign batt    = batt_q;
  assign busy    = busy_q;

endmodule
